// File: rtl/core_pkg.sv
// Shared definitions for the 64-bit RISC-V core pipeline: widths, the canonical
// NOP and the {pc, inst} packet carried from fetch to decode.
package core_pkg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    // addi x0, x0, 0
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_pkt_t;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

endpackage : core_pkg

// File: rtl/if_id_skid_buffer.sv
// Two-entry skid buffer at the IF/ID boundary. if_ready is a function of the
// registered count only, so decode back-pressure never reaches fetch combinationally.
module if_id_skid_buffer #(
    parameter int                 PC_W     = core_pkg::PC_W,
    parameter int                 INST_W   = core_pkg::INST_W,
    parameter logic [INST_W-1:0]  NOP_INST = core_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [PC_W-1:0]   if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    input  logic              flush,
    output logic              id_valid,
    output logic [PC_W-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst,
    input  logic              id_ready,
    output logic [1:0]        occupancy
);
    import core_pkg::*;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } slot_t;

    slot_t      slot0_q, slot0_d;
    slot_t      slot1_q, slot1_d;
    logic [1:0] cnt_q, cnt_d;
    logic       push;
    logic       pop;
    slot_t      in_pkt;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        cnt_d     = cnt_q;
        in_pkt    = '{pc: if_pc, inst: if_inst};

        if_ready  = (cnt_q != CNT_FULL);
        id_valid  = (cnt_q != CNT_EMPTY);
        id_pc     = id_valid ? slot0_q.pc   : '0;
        id_inst   = id_valid ? slot0_q.inst : NOP_INST;
        occupancy = cnt_q;

        push = if_valid & if_ready;
        pop  = id_valid & id_ready;

        // Flush wins over any handshake; stale slot contents are harmless once cnt is 0.
        if (flush) begin
            cnt_d = CNT_EMPTY;
        end else begin
            case (cnt_q)
                CNT_EMPTY: begin
                    if (push) begin
                        slot0_d = in_pkt;
                        cnt_d   = CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (push && pop) begin
                        slot0_d = in_pkt;
                    end else if (push) begin
                        slot1_d = in_pkt;
                        cnt_d   = CNT_FULL;
                    end else if (pop) begin
                        cnt_d   = CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    if (pop) begin
                        slot0_d = slot1_q;
                        cnt_d   = CNT_ONE;
                    end
                end
                default: cnt_d = CNT_EMPTY;
            endcase
        end
    end

    // NOTE: the two data slots are reset alongside the count so the head is defined from time zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= CNT_EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt_q   <= cnt_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

endmodule : if_id_skid_buffer

// File: tb/tb_if_id_skid_buffer.sv
// Self-checking bench for if_id_skid_buffer: a queue scoreboard mirrors the
// entries that should be buffered and is compared against id_* every cycle.
module tb_if_id_skid_buffer;
    import core_pkg::*;

    logic              clk;
    logic              reset;
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              flush;
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_ready;
    logic [1:0]        occupancy;

    int n_checks = 0;
    int n_errors = 0;

    fetch_pkt_t sb_q[$];

    if_id_skid_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .if_ready  (if_ready),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_pc     (id_pc),
        .id_inst   (id_inst),
        .id_ready  (id_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs against the scoreboard state, which is the expected content.
    task automatic check_outputs(input string tag);
        int sz;
        sz = sb_q.size();
        check({tag, ".if_ready"}, 64'(if_ready), 64'(sz != 2));
        check({tag, ".id_valid"}, 64'(id_valid), 64'(sz != 0));
        check({tag, ".occupancy"}, 64'(occupancy), 64'(sz));
        if (sz != 0) begin
            check({tag, ".id_pc"}, id_pc, sb_q[0].pc);
            check({tag, ".id_inst"}, 64'(id_inst), 64'(sb_q[0].inst));
        end else begin
            check({tag, ".id_pc"}, id_pc, 64'h0);
            check({tag, ".id_inst"}, 64'(id_inst), 64'h0000_0013);
        end
    endtask

    // One clock cycle: drive at the falling edge, check before the rising edge,
    // then advance the scoreboard exactly as the handshake dictates.
    task automatic cycle(input logic v, input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                         input logic rdy, input logic fl, input string tag, output logic acc);
        logic exp_ready;
        logic exp_pop;
        fetch_pkt_t pkt;
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
        flush    = fl;
        #1;
        check_outputs(tag);
        exp_ready = (sb_q.size() != 2);
        exp_pop   = (sb_q.size() != 0) && rdy && !fl;
        acc       = v && exp_ready && !fl;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (exp_pop) void'(sb_q.pop_front());
            if (acc) begin
                pkt.pc   = pc;
                pkt.inst = inst;
                sb_q.push_back(pkt);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy, input string tag);
        logic acc;
        cycle(1'b0, '0, '0, rdy, 1'b0, tag, acc);
    endtask

    // Present one pair until accepted, with a bounded number of attempts.
    task automatic send(input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                        input logic rdy, input string tag);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            cycle(1'b1, pc, inst, rdy, 1'b0, tag, acc);
        end
        if (!acc) check({tag, ".send_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        logic acc;
        logic [PC_W-1:0] pc_r;

        reset    = 1'b0;
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        id_ready = 1'b0;
        flush    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs("reset");

        @(negedge clk);
        // Streaming: four back-to-back pairs with decode always ready.
        for (int i = 0; i < 4; i++) begin
            send(64'(i * 4), 32'hA0 + 32'(i), 1'b1, "stream");
            check("stream.occ_le1", 64'(occupancy <= 2'd1), 64'd1);
        end
        idle(1'b1, "stream_drain");
        idle(1'b1, "stream_empty");

        // Stall: decode not ready, two pairs absorbed, third held off.
        send(64'h0, 32'hB0, 1'b0, "stall");
        send(64'h4, 32'hB1, 1'b0, "stall");
        cycle(1'b1, 64'h8, 32'hB2, 1'b0, 1'b0, "stall_full", acc);
        check("stall.occ", 64'(occupancy), 64'd2);
        check("stall.if_ready", 64'(if_ready), 64'd0);
        check("stall.held_off", 64'(acc), 64'd0);
        send(64'h8, 32'hB2, 1'b1, "unstall");
        idle(1'b1, "unstall_drain");
        idle(1'b1, "unstall_empty");

        // Simultaneous push and pop with one entry held.
        send(64'h10, 32'hC0, 1'b0, "pushpop_fill");
        send(64'h14, 32'hC1, 1'b1, "pushpop");
        #1;
        check("pushpop.id_pc", id_pc, 64'h14);
        check("pushpop.occ", 64'(occupancy), 64'd1);
        idle(1'b1, "pushpop_drain");

        // Flush at full occupancy together with a presented pair.
        send(64'h18, 32'hD0, 1'b0, "flush_fill");
        send(64'h1C, 32'hD1, 1'b0, "flush_fill");
        cycle(1'b1, 64'h20, 32'hD2, 1'b1, 1'b1, "flush", acc);
        #1;
        check("flush.id_valid", 64'(id_valid), 64'd0);
        check("flush.occ", 64'(occupancy), 64'd0);
        check("flush.if_ready", 64'(if_ready), 64'd1);
        idle(1'b1, "post_flush");
        idle(1'b1, "post_flush");

        // Asynchronous reset between clock edges while full.
        send(64'h24, 32'hE0, 1'b0, "areset_fill");
        send(64'h28, 32'hE1, 1'b0, "areset_fill");
        if_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        sb_q.delete();
        check("areset.id_valid", 64'(id_valid), 64'd0);
        check("areset.occ", 64'(occupancy), 64'd0);
        check("areset.if_ready", 64'(if_ready), 64'd1);
        check("areset.id_inst", 64'(id_inst), 64'h13);
        check("areset.id_pc", id_pc, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Random traffic with occasional flushes; the scoreboard tracks every entry.
        pc_r = 64'h1000;
        for (int i = 0; i < 300; i++) begin
            logic v, r, f;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 19) == 0);
            cycle(v, pc_r, $urandom, r, f, "random", acc);
            if (acc) pc_r = pc_r + 64'd4;
        end
        for (int i = 0; i < 3; i++) idle(1'b1, "final_drain");
        check("final.empty", 64'(id_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_if_id_skid_buffer
